// File: rtl/sram_l1_pkg.sv
// Shared types and defaults for the L1 data-store SRAM wrapper.
package sram_l1_pkg;

  localparam int unsigned READ_LATENCY  = 6;
  localparam int unsigned L1_NUM_WMASKS = 4;
  localparam int unsigned L1_DATA_WIDTH = 33;
  localparam int unsigned L1_ADDR_WIDTH = 9;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StReadWait,
    StReady
  } sram_state_e;

endpackage

// File: rtl/sram_l1_macro.sv
// Behavioral single-port SRAM macro: byte-masked synchronous write, registered read.
module sram_l1_macro
  import sram_l1_pkg::*;
#(
  parameter int unsigned NUM_WMASKS = L1_NUM_WMASKS,
  parameter int unsigned DATA_WIDTH = L1_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = L1_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0
);

  localparam int unsigned Words = 2 ** ADDR_WIDTH;

  // Contents start at zero and are never touched by reset.
  logic [DATA_WIDTH-1:0] mem [Words] = '{default: '0};

  always_ff @(posedge clk) begin
    if (!csb0 && !web0) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
      end
      if (|wmask0) mem[addr0][DATA_WIDTH-1] <= din0[DATA_WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!csb0 && web0) dout0 <= mem[addr0];
  end

endmodule

// File: rtl/sram_l1_wrap.sv
// L1 data-store wrapper: command FSM, fixed read-latency counter and registered outputs.
module sram_l1_wrap
  import sram_l1_pkg::*;
#(
  parameter int unsigned NUM_WMASKS = L1_NUM_WMASKS,
  parameter int unsigned DATA_WIDTH = L1_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = L1_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csb,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-2:0] data_in,
  input  logic [NUM_WMASKS-1:0] wmask,
  output logic [DATA_WIDTH-2:0] data_out,
  output logic                  data_ready
);

  localparam int unsigned CntW = $clog2(READ_LATENCY);

  sram_state_e           state_q;
  logic [CntW-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  wr_now;
  logic                  mem_csb;
  logic                  mem_web;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_dout;

  // Writes commit on the very edge IDLE samples them, so the macro sees the ports directly.
  always_comb begin
    wr_now   = (state_q == StIdle) && !csb && !we;
    mem_csb  = !(wr_now || (state_q == StReadWait));
    mem_web  = !wr_now;
    mem_addr = wr_now ? addr : addr_q;
  end

  sram_l1_macro #(
    .NUM_WMASKS(NUM_WMASKS),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_macro (
    .clk   (clk),
    .csb0  (mem_csb),
    .web0  (mem_web),
    .wmask0(wmask),
    .addr0 (mem_addr),
    .din0  ({|wmask, data_in}),
    .dout0 (mem_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_out   <= '0;
      data_ready <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!csb) begin
            addr_q <= addr;
            if (!we) begin
              state_q <= StWrite;
            end else begin
              cnt_q   <= '0;
              state_q <= StReadWait;
            end
          end
        end
        StWrite: begin
          if (csb) state_q <= StIdle;
        end
        StReadWait: begin
          if (csb) begin
            state_q <= StIdle;
          end else if (cnt_q == CntW'(READ_LATENCY - 1)) begin
            // Never-written words read as zero regardless of stale payload bits.
            data_out   <= mem_dout[DATA_WIDTH-1] ? mem_dout[DATA_WIDTH-2:0] : '0;
            data_ready <= 1'b1;
            state_q    <= StReady;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StReady: begin
          if (csb) begin
            data_ready <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_l1_wrap.sv
// Directed self-checking bench for sram_l1_wrap.
module tb_sram_l1_wrap;

  logic        clk;
  logic        rst_n;
  logic        csb;
  logic        we;
  logic [8:0]  addr;
  logic [31:0] data_in;
  logic [3:0]  wmask;
  logic [31:0] data_out;
  logic        data_ready;

  int n_checks = 0;
  int n_fail   = 0;

  sram_l1_wrap dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .csb       (csb),
    .we        (we),
    .addr      (addr),
    .data_in   (data_in),
    .wmask     (wmask),
    .data_out  (data_out),
    .data_ready(data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
    csb = 1'b0; we = 1'b0; addr = a; data_in = d; wmask = m;
    tick();
    tick();
    csb = 1'b1; we = 1'b1;
    tick();
  endtask

  // Issues a read, checks data_ready stays low for 5 edges, then rises with exp on edge 6.
  task automatic do_read(input string tag, input logic [8:0] a, input logic [31:0] exp);
    csb = 1'b0; we = 1'b1; addr = a;
    tick();
    for (int k = 1; k < 6; k++) begin
      tick();
      check_eq({tag, "_early"}, {31'd0, data_ready}, 32'd0);
    end
    tick();
    check_eq({tag, "_ready"}, {31'd0, data_ready}, 32'd1);
    check_eq({tag, "_data"}, data_out, exp);
    csb = 1'b1;
    tick();
    check_eq({tag, "_drop"}, {31'd0, data_ready}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; csb = 1'b1; we = 1'b1; addr = '0; data_in = '0; wmask = '0;
    #22;
    check_eq("rst_ready", {31'd0, data_ready}, 32'd0);
    check_eq("rst_data", data_out, 32'd0);
    rst_n = 1'b1;
    tick();

    do_write(9'd48, 32'd77, 4'b1111);
    do_write(9'd49, 32'd1, 4'b1111);
    do_read("rd48", 9'd48, 32'd77);
    do_read("rd49", 9'd49, 32'd1);

    do_write(9'd5, 32'hAABBCCDD, 4'b1111);
    do_write(9'd5, 32'h11223344, 4'b0001);
    do_read("rd5_mask", 9'd5, 32'hAABBCC44);

    do_read("rd300_unwritten", 9'd300, 32'd0);

    // Abort a read after 3 cycles in READ_WAIT.
    csb = 1'b0; we = 1'b1; addr = 9'd48;
    tick();
    tick();
    tick();
    csb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq("abort_ready", {31'd0, data_ready}, 32'd0);
    end
    do_read("rd_after_abort", 9'd49, 32'd1);

    // Asynchronous reset in the middle of a read.
    csb = 1'b0; we = 1'b1; addr = 9'd5;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_ready", {31'd0, data_ready}, 32'd0);
    check_eq("rstmid_data", data_out, 32'd0);
    csb = 1'b1;
    #2;
    rst_n = 1'b1;
    tick();
    do_read("rd5_after_rst", 9'd5, 32'hAABBCC44);

    // READY holds its outputs while addr/we wiggle under csb low.
    csb = 1'b0; we = 1'b1; addr = 9'd48;
    tick();
    for (int k = 0; k < 6; k++) tick();
    check_eq("hold_ready0", {31'd0, data_ready}, 32'd1);
    check_eq("hold_data0", data_out, 32'd77);
    for (int k = 0; k < 10; k++) begin
      addr = 9'(k + 1);
      we   = k[0];
      tick();
      check_eq("hold_ready", {31'd0, data_ready}, 32'd1);
      check_eq("hold_data", data_out, 32'd77);
    end
    csb = 1'b1; we = 1'b1;
    tick();
    check_eq("hold_drop", {31'd0, data_ready}, 32'd0);
    check_eq("hold_keep_data", data_out, 32'd77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
